// File: rtl/vector_mem_pkg.sv
// Shared types and constants for the vector memory sequencer.
package vector_mem_pkg;

  localparam int WORD_SIZE = 32;

  // Element size encoding as carried on CmdSize.
  typedef enum logic [1:0] {
    SIZE_B       = 2'b00,
    SIZE_H       = 2'b01,
    SIZE_W       = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } seq_state_t;

endpackage

// File: rtl/vector_lane_align.sv
// Combinational lane steering for one vector element: byte enables,
// replicated store data, extended load value and misalignment flag.
module vector_lane_align
  import vector_mem_pkg::*;
(
  input  mem_size_t              i_size,
  input  logic                   i_signed,
  input  logic [1:0]             i_ea_lo,
  input  logic [WORD_SIZE-1:0]   i_elem,
  input  logic [WORD_SIZE-1:0]   i_mem_data,
  output logic [3:0]             o_byte_en,
  output logic [WORD_SIZE-1:0]   o_wdata,
  output logic [WORD_SIZE-1:0]   o_load_val,
  output logic                   o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane of MemData and build per-size access controls.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    o_byte_en  = 4'b0000;
    o_wdata    = '0;
    o_load_val = '0;
    o_misalign = 1'b0;
    w_byte     = 8'(i_mem_data >> {i_ea_lo, 3'b000});
    w_half     = i_ea_lo[1] ? i_mem_data[31:16] : i_mem_data[15:0];

    case (i_size)
      SIZE_B: begin
        o_byte_en  = 4'b0001 << i_ea_lo;
        o_wdata    = {4{i_elem[7:0]}};
        o_load_val = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      end
      SIZE_H: begin
        o_byte_en  = i_ea_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_elem[15:0]}};
        o_load_val = i_signed ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
        o_misalign = i_ea_lo[0];
      end
      SIZE_W: begin
        o_byte_en  = 4'b1111;
        o_wdata    = i_elem;
        o_load_val = i_mem_data;
        o_misalign = |i_ea_lo;
      end
      default: begin
        // Illegal size never reaches RUN; defaults apply.
      end
    endcase
  end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Strided vector load/store sequencer driving the word-wide vector storage
// port, one element access per cycle.
// Optional feature: define VECTOR_SEQ_MASK_EN to add the CmdMask input,
// which turns masked-off elements into idle cycles (loads write zero).
module vector_mem_sequencer
  import vector_mem_pkg::*;
#(
  parameter  int ADRESS_SIZE  = 10,
  parameter  int MAX_ELEMENTS = 8,
  localparam int CNT_BITS     = $clog2(MAX_ELEMENTS + 1)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              CmdValid,
  output logic                              CmdReady,
  input  logic                              CmdWrite,
  input  logic [1:0]                        CmdSize,
  input  logic                              CmdSigned,
  input  logic [ADRESS_SIZE-1:0]            CmdBase,
  input  logic [ADRESS_SIZE-1:0]            CmdStride,
  input  logic [CNT_BITS-1:0]               CmdCount,
`ifdef VECTOR_SEQ_MASK_EN
  input  logic [MAX_ELEMENTS-1:0]           CmdMask,
`endif
  input  logic [MAX_ELEMENTS*WORD_SIZE-1:0] StoreVector,
  output logic [MAX_ELEMENTS*WORD_SIZE-1:0] LoadVector,
  output logic                              Done,
  output logic                              Error,
  output logic                              MemEn,
  output logic                              WriteEnable,
  output logic [3:0]                        ByteEn,
  output logic [ADRESS_SIZE-1:0]            MemoryAdress,
  output logic [WORD_SIZE-1:0]              WriteData,
  input  logic [WORD_SIZE-1:0]              MemData
);

  localparam int IDX_BITS = $clog2(MAX_ELEMENTS);

  seq_state_t                        r_state;
  seq_state_t                        w_next_state;
  logic                              r_write;
  mem_size_t                         r_size;
  logic                              r_signed;
  logic [ADRESS_SIZE-1:0]            r_stride;
  logic [ADRESS_SIZE-1:0]            r_addr;
  logic [CNT_BITS-1:0]               r_count;
  logic [CNT_BITS-1:0]               r_idx;
  logic [MAX_ELEMENTS*WORD_SIZE-1:0] r_store_vec;
  logic [MAX_ELEMENTS*WORD_SIZE-1:0] r_load_vec;
  logic                              r_error;
`ifdef VECTOR_SEQ_MASK_EN
  logic [MAX_ELEMENTS-1:0]           r_mask;
`endif

  logic [IDX_BITS-1:0]  w_idx;
  logic [WORD_SIZE-1:0] w_elem;
  logic [3:0]           w_byte_en;
  logic [WORD_SIZE-1:0] w_wdata;
  logic [WORD_SIZE-1:0] w_load_val;
  logic                 w_misalign;
  logic                 w_active;
  logic                 w_run;
  logic                 w_accept;
  logic                 w_abort;
  logic                 w_last;

  assign w_idx    = r_idx[IDX_BITS-1:0];
  assign w_elem   = r_store_vec[WORD_SIZE*w_idx +: WORD_SIZE];
  assign w_run    = (r_state == RUN);
  assign w_accept = (r_state == IDLE) && CmdValid;
`ifdef VECTOR_SEQ_MASK_EN
  assign w_active = r_mask[w_idx];
`else
  assign w_active = 1'b1;
`endif
  // A masked-off element skips the alignment check entirely.
  assign w_abort  = w_run && w_active && w_misalign;
  assign w_last   = (r_idx == r_count - CNT_BITS'(1));

  vector_lane_align u_lane_align (
    .i_size     (r_size),
    .i_signed   (r_signed),
    .i_ea_lo    (r_addr[1:0]),
    .i_elem     (w_elem),
    .i_mem_data (MemData),
    .o_byte_en  (w_byte_en),
    .o_wdata    (w_wdata),
    .o_load_val (w_load_val),
    .o_misalign (w_misalign)
  );

  // Storage port is driven combinationally from the registered element state.
  assign MemEn        = w_run && w_active && !w_misalign;
  assign WriteEnable  = MemEn && r_write;
  assign ByteEn       = w_run ? w_byte_en : 4'b0000;
  assign MemoryAdress = w_run ? {r_addr[ADRESS_SIZE-1:2], 2'b00} : '0;
  assign WriteData    = w_run ? w_wdata : '0;
  assign CmdReady     = (r_state == IDLE);
  assign Done         = (r_state == FINISH);
  assign Error        = r_error;
  assign LoadVector   = r_load_vec;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: accept, walk elements, stop on last or misaligned.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (CmdValid) begin
          if ((CmdCount == '0) || (CmdSize == SIZE_ILLEGAL)) w_next_state = FINISH;
          else                                                w_next_state = RUN;
        end
      end
      RUN:     if (w_abort || w_last) w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Command latch, element walker and load gather register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the gathered load vector is architecturally visible and must
      // read zero after reset, so this wide register is reset like the rest.
      r_write     <= 1'b0;
      r_size      <= SIZE_B;
      r_signed    <= 1'b0;
      r_stride    <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_store_vec <= '0;
      r_load_vec  <= '0;
      r_error     <= 1'b0;
`ifdef VECTOR_SEQ_MASK_EN
      r_mask      <= '0;
`endif
    end else if (w_accept) begin
      r_write     <= CmdWrite;
      r_size      <= mem_size_t'(CmdSize);
      r_signed    <= CmdSigned;
      r_stride    <= CmdStride;
      r_addr      <= CmdBase;
      r_count     <= CmdCount;
      r_idx       <= '0;
      r_store_vec <= StoreVector;
      r_error     <= (CmdSize == SIZE_ILLEGAL);
`ifdef VECTOR_SEQ_MASK_EN
      r_mask      <= CmdMask;
`endif
    end else if (w_run) begin
      if (w_abort) begin
        r_error <= 1'b1;
      end else begin
        if (!r_write) begin
          r_load_vec[WORD_SIZE*w_idx +: WORD_SIZE] <= w_active ? w_load_val : '0;
        end
        r_idx  <= r_idx + CNT_BITS'(1);
        r_addr <= r_addr + r_stride;
      end
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed self-checking bench for vector_mem_sequencer with a word-wide
// storage model answering MemData combinationally.
module tb_vector_mem_sequencer;
  import vector_mem_pkg::*;

  localparam int AW = 10;
  localparam int NE = 8;
  localparam int CB = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            CmdValid = 1'b0;
  logic            CmdReady;
  logic            CmdWrite = 1'b0;
  logic [1:0]      CmdSize = 2'b00;
  logic            CmdSigned = 1'b0;
  logic [AW-1:0]   CmdBase = '0;
  logic [AW-1:0]   CmdStride = '0;
  logic [CB-1:0]   CmdCount = '0;
  logic [NE*32-1:0] StoreVector = '0;
  logic [NE*32-1:0] LoadVector;
  logic            Done;
  logic            Error;
  logic            MemEn;
  logic            WriteEnable;
  logic [3:0]      ByteEn;
  logic [AW-1:0]   MemoryAdress;
  logic [31:0]     WriteData;
  logic [31:0]     MemData;

  int checks = 0;
  int failures = 0;

  // Storage model with a preload port used only while the sequencer is idle.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign MemData = mem[MemoryAdress[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (MemEn && WriteEnable) begin
      for (int b = 0; b < 4; b++)
        if (ByteEn[b]) mem[MemoryAdress[9:2]][8*b +: 8] <= WriteData[8*b +: 8];
    end
  end

  always #5 clk = ~clk;

  vector_mem_sequencer #(.ADRESS_SIZE(AW), .MAX_ELEMENTS(NE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .CmdValid     (CmdValid),
    .CmdReady     (CmdReady),
    .CmdWrite     (CmdWrite),
    .CmdSize      (CmdSize),
    .CmdSigned    (CmdSigned),
    .CmdBase      (CmdBase),
    .CmdStride    (CmdStride),
    .CmdCount     (CmdCount),
    .StoreVector  (StoreVector),
    .LoadVector   (LoadVector),
    .Done         (Done),
    .Error        (Error),
    .MemEn        (MemEn),
    .WriteEnable  (WriteEnable),
    .ByteEn       (ByteEn),
    .MemoryAdress (MemoryAdress),
    .WriteData    (WriteData),
    .MemData      (MemData)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Offer one command; returns #1 after the accept edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input logic [CB-1:0] cnt);
    CmdWrite = wr; CmdSize = sz; CmdSigned = sg;
    CmdBase = base; CmdStride = stride; CmdCount = cnt;
    CmdValid = 1'b1;
    tick();
    CmdValid = 1'b0;
  endtask

  // Cycles from the accept point until Done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!Done && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [31:0] lv(input int i);
    return LoadVector[32*i +: 32];
  endfunction

  int cyc;

  initial begin
    // Reset values.
    #12;
    check("rst_ready",  32'(CmdReady), 32'd1);
    check("rst_done",   32'(Done), 32'd0);
    check("rst_error",  32'(Error), 32'd0);
    check("rst_memen",  32'(MemEn), 32'd0);
    check("rst_we",     32'(WriteEnable), 32'd0);
    check("rst_byteen", 32'(ByteEn), 32'd0);
    check("rst_addr",   32'(MemoryAdress), 32'd0);
    check("rst_wdata",  WriteData, 32'd0);
    check("rst_lvec",   32'(|LoadVector), 32'd0);
    reset_n = 1'b1;
    tick();

    preload(8'd4, 32'h11111111);
    preload(8'd5, 32'h22222222);
    preload(8'd6, 32'h33333333);
    preload(8'd0, 32'h80AABBCC);
    preload(8'd1, 32'h5566777F);
    preload(8'd8, 32'hAAAAAAAA);
    preload(8'd9, 32'hBBBBBBBB);
    for (int w = 16; w < 20; w++) preload(8'(w), 32'h00000000);

    // Word load, 3 elements. Done occupies the cycle ending N+1 edges after
    // accept, so it is first seen N edges after the accept sample point.
    issue(1'b0, SIZE_W, 1'b0, 10'h010, 10'd4, 4'd3);
    check("wl_memen",  32'(MemEn), 32'd1);
    check("wl_we",     32'(WriteEnable), 32'd0);
    check("wl_byteen", 32'(ByteEn), 32'hF);
    check("wl_addr",   32'(MemoryAdress), 32'h010);
    wait_done(cyc);
    check("wl_done",   32'(Done), 32'd1);
    check("wl_lat",    32'(cyc), 32'd3);
    check("wl_error",  32'(Error), 32'd0);
    check("wl_lv0",    lv(0), 32'h11111111);
    check("wl_lv1",    lv(1), 32'h22222222);
    check("wl_lv2",    lv(2), 32'h33333333);
    tick();
    check("wl_done_1cyc", 32'(Done), 32'd0);
    check("wl_ready",  32'(CmdReady), 32'd1);

    // Signed byte load crossing a word boundary.
    issue(1'b0, SIZE_B, 1'b1, 10'h003, 10'd1, 4'd2);
    check("sb_byteen0", 32'(ByteEn), 32'h8);
    check("sb_addr0",   32'(MemoryAdress), 32'h000);
    tick();
    check("sb_byteen1", 32'(ByteEn), 32'h1);
    check("sb_addr1",   32'(MemoryAdress), 32'h004);
    tick();
    check("sb_done",    32'(Done), 32'd1);
    check("sb_lv0",     lv(0), 32'hFFFFFF80);
    check("sb_lv1",     lv(1), 32'h0000007F);
    check("sb_lv2_hold", lv(2), 32'h33333333);
    tick();

    // Halfword store to the upper lanes of two words.
    StoreVector = '0;
    StoreVector[31:0]  = 32'h1234BEEF;
    StoreVector[63:32] = 32'h5678CAFE;
    issue(1'b1, SIZE_H, 1'b0, 10'h022, 10'd4, 4'd2);
    check("hs_we0",     32'(WriteEnable), 32'd1);
    check("hs_byteen0", 32'(ByteEn), 32'hC);
    check("hs_wdata0",  WriteData, 32'hBEEFBEEF);
    check("hs_addr0",   32'(MemoryAdress), 32'h020);
    tick();
    check("hs_byteen1", 32'(ByteEn), 32'hC);
    check("hs_wdata1",  WriteData, 32'hCAFECAFE);
    check("hs_addr1",   32'(MemoryAdress), 32'h024);
    tick();
    check("hs_done",    32'(Done), 32'd1);
    check("hs_mem8",    mem[8], 32'hBEEFAAAA);
    check("hs_mem9",    mem[9], 32'hCAFEBBBB);
    check("hs_lv0_kept", lv(0), 32'hFFFFFF80);
    tick();

    // Word load that misaligns on element 1.
    issue(1'b0, SIZE_W, 1'b0, 10'h004, 10'd2, 4'd3);
    check("ma_memen0", 32'(MemEn), 32'd1);
    check("ma_addr0",  32'(MemoryAdress), 32'h004);
    tick();
    check("ma_memen1", 32'(MemEn), 32'd0);
    check("ma_nodone", 32'(Done), 32'd0);
    tick();
    check("ma_done",   32'(Done), 32'd1);
    check("ma_error",  32'(Error), 32'd1);
    check("ma_lv0",    lv(0), 32'h5566777F);
    check("ma_lv1",    lv(1), 32'h0000007F);
    tick();

    // Zero-count command, then illegal size.
    issue(1'b0, SIZE_W, 1'b0, 10'h000, 10'd4, 4'd0);
    check("z_done",   32'(Done), 32'd1);
    check("z_error",  32'(Error), 32'd0);
    check("z_memen",  32'(MemEn), 32'd0);
    tick();
    issue(1'b0, SIZE_ILLEGAL, 1'b0, 10'h000, 10'd4, 4'd3);
    check("il_done",  32'(Done), 32'd1);
    check("il_error", 32'(Error), 32'd1);
    check("il_memen", 32'(MemEn), 32'd0);
    tick();

    // Reset in the middle of a 4-element word store after 2 elements.
    StoreVector = '0;
    StoreVector[31:0]   = 32'hA0A0A0A0;
    StoreVector[63:32]  = 32'hB1B1B1B1;
    StoreVector[95:64]  = 32'hC2C2C2C2;
    StoreVector[127:96] = 32'hD3D3D3D3;
    issue(1'b1, SIZE_W, 1'b0, 10'h040, 10'd4, 4'd4);
    tick();
    tick();
    check("rs_midrun_memen", 32'(MemEn), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rs_ready",  32'(CmdReady), 32'd1);
    check("rs_done",   32'(Done), 32'd0);
    check("rs_memen",  32'(MemEn), 32'd0);
    check("rs_we",     32'(WriteEnable), 32'd0);
    check("rs_byteen", 32'(ByteEn), 32'd0);
    check("rs_addr",   32'(MemoryAdress), 32'd0);
    check("rs_wdata",  WriteData, 32'd0);
    check("rs_lvec",   32'(|LoadVector), 32'd0);
    tick();
    check("rs_nodone0", 32'(Done), 32'd0);
    #2 reset_n = 1'b1;
    tick();
    check("rs_nodone1", 32'(Done), 32'd0);
    check("rs_ready2",  32'(CmdReady), 32'd1);
    check("rs_mem16",   mem[16], 32'hA0A0A0A0);
    check("rs_mem17",   mem[17], 32'hB1B1B1B1);
    check("rs_mem18",   mem[18], 32'h00000000);
    check("rs_mem19",   mem[19], 32'h00000000);

    // Unsigned byte load after recovery.
    issue(1'b0, SIZE_B, 1'b0, 10'h003, 10'd1, 4'd1);
    check("ub_byteen", 32'(ByteEn), 32'h8);
    tick();
    check("ub_done",   32'(Done), 32'd1);
    check("ub_error",  32'(Error), 32'd0);
    check("ub_lv0",    lv(0), 32'h00000080);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Initiator for the word-wide vector storage port. It drives MemEn, WriteEnable, ByteEn, address and write data, and consumes the storage's combinational MemData.
- Takes one strided vector load or store command from the pipeline and issues one element access per cycle.
- Steers byte and halfword lanes, sign- or zero-extends load elements, and pulses Done on completion.
- Sits between the vector execute stage and vectorStorage.

Parameters:
- ADRESS_SIZE, 10, byte-address width driven to storage.
- MAX_ELEMENTS, 8, maximum elements per command; must be a power of 2, at least 2.
- CNT_BITS, $clog2(MAX_ELEMENTS+1), width of the element-count field (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- CmdValid  in  1  command offered.
- CmdReady  out  1  sequencer can accept a command.
- CmdWrite  in  1  1 = store, 0 = load.
- CmdSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
- CmdSigned  in  1  sign-extend load elements.
- CmdBase  in  ADRESS_SIZE  byte address of element 0.
- CmdStride  in  ADRESS_SIZE  byte stride between elements (unsigned, wraps).
- CmdCount  in  CNT_BITS  element count, 0..MAX_ELEMENTS.
- StoreVector  in  MAX_ELEMENTS*32  store elements; element i in bits [32i+31:32i], low CmdSize bytes used.
- LoadVector  out  MAX_ELEMENTS*32  gathered load elements, extended to 32 bits.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  set with Done if the command aborted.
- MemEn  out  1  storage access enable.
- WriteEnable  out  1  storage write.
- ByteEn  out  4  storage byte lanes.
- MemoryAdress  out  ADRESS_SIZE  word-aligned address (low 2 bits zero).
- WriteData  out  32  lane-steered store data.
- MemData  in  32  storage read data, combinational from address.

Behaviour:
- Reset (async, reset_n=0): state IDLE; CmdReady=1; Done, Error, MemEn, WriteEnable=0; ByteEn=0; MemoryAdress=0; WriteData=0; LoadVector=0.
- Reset mid-command aborts immediately with no Done. Storage writes already committed remain.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - CmdReady=1.
  - On CmdValid, latch all Cmd* fields and StoreVector, clear Error, set index i=0 and addr=CmdBase.
  - If CmdCount=0 or CmdSize=11, go to FINISH, with Error=1 when CmdSize=11. Otherwise go to RUN.
  - No storage access happens in the accept cycle.
- RUN:
  - CmdReady=0. One element per cycle; all memory outputs are combinational from the registered i and addr.
  - Element address ea=addr; MemoryAdress={ea[ADRESS_SIZE-1:2],2'b00}.
  - ByteEn: byte gives 1<<ea[1:0]; half gives 0011 or 1100 by ea[1]; word gives 1111.
  - WriteData: element replicated into every lane of its size (byte x4, half x2).
  - Load: the selected lane of MemData is sign- or zero-extended and written to LoadVector[i] at the clock edge.
  - Store: MemEn=1 and WriteEnable=1, so storage commits at the edge.
  - Misaligned element (half with ea[0]=1; word with ea[1:0]!=0): MemEn=0 for that cycle, Error=1, go to FINISH. Elements < i are completed; elements >= i are untouched.
  - After each good element: i++, addr=addr+CmdStride mod 2^ADRESS_SIZE. On i=CmdCount-1, go to FINISH.
- FINISH: Done=1 for exactly one cycle, CmdReady=0, go to IDLE.
- Latency: a command with N aligned elements gives Done N+1 cycles after the accept edge; an N=0 command gives Done 1 cycle after.
- LoadVector holds its value until overwritten by a later load; stores never modify it.
- Back-to-back: CmdValid during RUN or FINISH is ignored (CmdReady=0). The next accept is possible in the cycle after FINISH.

Optional Feature:
- VECTOR_SEQ_MASK_EN defined: adds input CmdMask [MAX_ELEMENTS-1:0], latched on accept.
  - Element i with mask bit 0 spends its cycle with MemEn=0 and no alignment check.
  - On a load it writes 0 to LoadVector[i].
  - Cycle count is unchanged.
- Undefined: port absent, all elements active.

Decomposition:
- Package vector_mem_pkg holds:
  - WORD_SIZE=32.
  - typedef enum mem_size_t {SIZE_B, SIZE_H, SIZE_W, SIZE_ILLEGAL}.
  - typedef enum seq_state_t {IDLE, RUN, FINISH}.
- One combinational sub-module, vector_lane_align, computes ByteEn, WriteData, the extended load value and the misalign flag from size, signed, ea[1:0], element and MemData.

Test Plan:
- Word load, base 0x010, stride 4, count 3, storage words 0x11111111/0x22222222/0x33333333 -> LoadVector[0..2] match; Done 4 cycles after accept; Error=0.
- Signed byte load, base 0x003, stride 1, count 2, word@0x000=0x80xxxxxx, byte@0x004=0x7F -> LoadVector[0]=0xFFFFFF80, [1]=0x0000007F; ByteEn 1000 then 0001.
- Half store, base 0x022, stride 4, count 2, elements 0xBEEF and 0xCAFE -> ByteEn=1100, WriteData=0xBEEFBEEF, then 0xCAFECAFE at 0x024. Other bytes unchanged on readback.
- Word load, base 0x004, stride 2, count 3 -> element 0 accessed, element 1 (0x006) gets MemEn=0; Done and Error=1 one cycle later; LoadVector[1] unchanged.
- CmdCount=0, then CmdSize=11 -> Done one cycle after accept, no MemEn; Error 0 then 1.
- reset_n low mid-RUN of a 4-element store after 2 elements -> all outputs at reset values asynchronously; no Done; only 2 words modified.
